// File: rtl/ps2_pkg.sv
// ============================================================================
//  Module   : ps2_pkg
//  Brief    : Shared constants and types for the PS/2 key decoder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [1:0] c_st_idle   = ST_IDLE;
    localparam logic [1:0] c_st_data   = ST_DATA;
    localparam logic [1:0] c_st_parity = ST_PARITY;
    localparam logic [1:0] c_st_stop   = ST_STOP;

    localparam logic [7:0] c_code_e0 = 8'hE0;
    localparam logic [7:0] c_code_f0 = 8'hF0;
    localparam logic [7:0] c_code_e1 = 8'hE1;

    localparam int unsigned c_key_toggle  = 10;
    localparam int unsigned c_key_pressed = 9;
    localparam int unsigned c_key_ext     = 8;

    localparam logic [2:0] c_e1_skip = 3'd7;

    // Keyboard status/response bytes that never carry a key code.
    function automatic logic is_drop_code(input logic [7:0] code);
        case (code)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_drop_code = 1'b1;
            default:                                          is_drop_code = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_key_decoder_if.sv
// ============================================================================
//  Module   : ps2_key_decoder_if
//  Brief    : Key-event bundle between the PS/2 decoder and its consumer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface ps2_key_decoder_if;
    logic [10:0] ps2_key;
    logic        err_parity;
    logic        err_frame;

    modport master (output ps2_key, output err_parity, output err_frame);
    modport slave  (input  ps2_key, input  err_parity, input  err_frame);
endinterface

`default_nettype wire

// File: rtl/ps2_line_filter.sv
// ============================================================================
//  Module   : ps2_line_filter
//  Brief    : Two-flop synchroniser followed by a run-length glitch filter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  wire logic clk_sys,
    input  wire logic reset_n,
    input  wire logic i_line,
    output logic      o_line
);

    localparam int c_cnt_w = $clog2(FILTER_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILTER_LEN - 1);

    logic               sync1_q;
    logic               sync2_q;
    logic               line_q;
    logic               line_d;
    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;

    // Count consecutive samples that disagree with the output; any agreeing sample restarts the run.
    always_comb begin
        line_d = line_q;
        cnt_d  = '0;
        if (sync2_q != line_q) begin
            if (cnt_q == c_cnt_last) begin
                line_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            line_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_line;
            sync2_q <= sync1_q;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_line = line_q;

endmodule

`default_nettype wire

// File: rtl/ps2_key_decoder.sv
// ============================================================================
//  Module   : ps2_key_decoder
//  Brief    : PS/2 device-to-host deserialiser producing toggle-qualified key events.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 49152
) (
    input  wire logic          clk_sys,
    input  wire logic          reset_n,
    input  wire logic          ps2_clk,
    input  wire logic          ps2_data,
    ps2_key_decoder_if.master  key_if
);

    localparam int c_to_w = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYC - 1);

    logic w_clk_f;
    logic w_data_f;
    logic w_fall;
    logic w_par_ok;

    logic              clk_prev_q;
    logic [1:0]        state_q,      state_d;
    logic [2:0]        bitcnt_q,     bitcnt_d;
    logic [7:0]        shift_q,      shift_d;
    logic              par_q,        par_d;
    logic [c_to_w-1:0] to_cnt_q,     to_cnt_d;
    logic              byte_valid_q, byte_valid_d;
    logic              err_parity_q, err_parity_d;
    logic              err_frame_q,  err_frame_d;
    logic              ext_q,        ext_d;
    logic              rel_q,        rel_d;
    logic [2:0]        skip_q,       skip_d;
    logic [10:0]       key_q,        key_d;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_line  (ps2_clk),
        .o_line  (w_clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_line  (ps2_data),
        .o_line  (w_data_f)
    );

    assign w_fall   = clk_prev_q & ~w_clk_f;
    assign w_par_ok = ^{shift_q, par_q};

    // Frame deserialiser; a falling clock edge always takes priority over the timeout.
    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        to_cnt_d     = to_cnt_q;
        byte_valid_d = 1'b0;
        err_parity_d = 1'b0;
        err_frame_d  = 1'b0;
        if (w_fall) begin
            to_cnt_d = '0;
            case (state_q)
                c_st_idle: begin
                    if (!w_data_f) begin
                        state_d  = c_st_data;
                        bitcnt_d = '0;
                    end
                end
                c_st_data: begin
                    shift_d  = {w_data_f, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = c_st_parity;
                    end
                end
                c_st_parity: begin
                    par_d   = w_data_f;
                    state_d = c_st_stop;
                end
                c_st_stop: begin
                    state_d = c_st_idle;
                    if (!w_par_ok) begin
                        err_parity_d = 1'b1;
                    end else if (!w_data_f) begin
                        err_frame_d = 1'b1;
                    end else begin
                        byte_valid_d = 1'b1;
                    end
                end
                default: state_d = c_st_idle;
            endcase
        end else if (state_q == c_st_idle) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == c_to_last) begin
            state_d     = c_st_idle;
            err_frame_d = 1'b1;
            to_cnt_d    = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // Prefix tracking and event emission. shift_q still holds the byte here:
    // the FSM sits in IDLE for at least one cycle after the stop bit.
    always_comb begin
        key_d  = key_q;
        ext_d  = ext_q;
        rel_d  = rel_q;
        skip_d = skip_q;
        if (err_parity_q || err_frame_q) begin
            ext_d  = 1'b0;
            rel_d  = 1'b0;
            skip_d = '0;
        end else if (byte_valid_q) begin
            if (skip_q != '0) begin
                skip_d = skip_q - 1'b1;
            end else if (shift_q == c_code_e0) begin
                ext_d = 1'b1;
            end else if (shift_q == c_code_f0) begin
                rel_d = 1'b1;
            end else if (shift_q == c_code_e1) begin
                skip_d = c_e1_skip;
                ext_d  = 1'b0;
                rel_d  = 1'b0;
            end else if (is_drop_code(shift_q)) begin
                ext_d = 1'b0;
                rel_d = 1'b0;
            end else begin
                key_d = {~key_q[c_key_toggle], ~rel_q, ext_q, shift_q};
                ext_d = 1'b0;
                rel_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_prev_q   <= 1'b1;
            state_q      <= c_st_idle;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            byte_valid_q <= 1'b0;
            err_parity_q <= 1'b0;
            err_frame_q  <= 1'b0;
            ext_q        <= 1'b0;
            rel_q        <= 1'b0;
            skip_q       <= '0;
            key_q        <= '0;
        end else begin
            clk_prev_q   <= w_clk_f;
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            to_cnt_q     <= to_cnt_d;
            byte_valid_q <= byte_valid_d;
            err_parity_q <= err_parity_d;
            err_frame_q  <= err_frame_d;
            ext_q        <= ext_d;
            rel_q        <= rel_d;
            skip_q       <= skip_d;
            key_q        <= key_d;
        end
    end

    assign key_if.ps2_key    = key_q;
    assign key_if.err_parity = err_parity_q;
    assign key_if.err_frame  = err_frame_q;

endmodule

`default_nettype wire
